// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one mantissa shifter with a registered response
module shift_arbiter #(
   parameter int M                   = 23,
   parameter int E                   = 8,
   parameter int extra_bits_mantissa = 7,
   parameter int N_REQ               = 2,
   localparam int W                  = M + extra_bits_mantissa,
   localparam int IW                 = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*W-1:0]     req_operand,
   input  logic [N_REQ*(E+1)-1:0] req_amount,
   input  logic [N_REQ-1:0]       req_right,
   input  logic [N_REQ-1:0]       req_arith,
   output logic [W-1:0]           shf_operand,
   output logic [E:0]             shf_amount,
   output logic                   shf_right,
   output logic                   shf_arith,
   input  logic [W-1:0]           shf_result,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [W-1:0]           resp_result,
   output logic [IW-1:0]          resp_id
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   next_ptr;
   logic [IW-1:0]   grant_idx;
   logic            grant_valid;
   logic            can_accept;
   logic            fire;
   int              cand;
   logic [IW-1:0]   cand_idx;

   logic [W-1:0]    operand_arr [N_REQ];
   logic [E:0]      amount_arr  [N_REQ];

   genvar g;
   generate
      for (g = 0; g < N_REQ; g++) begin : g_slice
         assign operand_arr[g] = req_operand[g*W +: W];
         assign amount_arr[g]  = req_amount[g*(E+1) +: (E+1)];
      end
   endgenerate

   // Search requesters starting at ptr, wrapping, and take the first valid one.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = cand[IW-1:0];
         if (!grant_valid && req_valid[cand_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // The response slot can take a new result when empty or when it drains this edge.
   always_comb begin
      can_accept = !rst && ((state_q == S_EMPTY) || resp_ready);
      fire       = can_accept && grant_valid;
      next_ptr   = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
   end

   // One-hot accept to the granted requester only; idle slices still steer the shifter from ptr.
   always_comb begin
      req_ready   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = fire && (grant_idx == IW'(i));
      end
      shf_operand = operand_arr[grant_idx];
      shf_amount  = amount_arr[grant_idx];
      shf_right   = req_right[grant_idx];
      shf_arith   = req_arith[grant_idx];
   end

   // Response slot next state: a grant always fills it, otherwise a drain empties it.
   always_comb begin
      state_d = state_q;
      if (fire) begin
         state_d = S_FULL;
      end else if ((state_q == S_FULL) && resp_ready) begin
         state_d = S_EMPTY;
      end
   end

   // Response slot state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the shifter result and its requester tag, and advance the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_result <= '0;
         resp_id     <= '0;
         ptr         <= '0;
      end else if (fire) begin
         resp_result <= shf_result;
         resp_id     <= grant_idx;
         ptr         <= next_ptr;
      end
   end

   assign resp_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed table-driven bench for shift_arbiter
module tb_shift_arbiter;

   localparam int M   = 23;
   localparam int E   = 8;
   localparam int XB  = 7;
   localparam int N   = 2;
   localparam int W   = M + XB;
   localparam int IW  = 1;

   typedef struct packed {
      logic [W-1:0] op;
      logic [E:0]   amt;
      logic         right;
      logic         arith;
   } rq_t;

   typedef struct {
      logic [1:0]   valid;
      rq_t          r0;
      rq_t          r1;
      logic         rr;
      logic [1:0]   exp_ready;
      logic         exp_rv;
      logic [W-1:0] exp_res;
      logic         exp_id;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N*W-1:0]       req_operand;
   logic [N*(E+1)-1:0]   req_amount;
   logic [N-1:0]         req_right;
   logic [N-1:0]         req_arith;
   logic [W-1:0]         shf_operand;
   logic [E:0]           shf_amount;
   logic                 shf_right;
   logic                 shf_arith;
   logic [W-1:0]         shf_result;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [W-1:0]         resp_result;
   logic [IW-1:0]        resp_id;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vecs[$];

   shift_arbiter #(.M(M), .E(E), .extra_bits_mantissa(XB), .N_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operand(req_operand), .req_amount(req_amount),
      .req_right(req_right), .req_arith(req_arith),
      .shf_operand(shf_operand), .shf_amount(shf_amount),
      .shf_right(shf_right), .shf_arith(shf_arith),
      .shf_result(shf_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_id(resp_id)
   );

   always #5 clk = ~clk;

   // Behavioural model of the external combinational mantissa shifter.
   always_comb begin
      if (int'(shf_amount) >= W) begin
         shf_result = (shf_right && shf_arith) ? {W{shf_operand[W-1]}} : '0;
      end else if (shf_right) begin
         if (shf_arith) shf_result = $signed(shf_operand) >>> shf_amount;
         else           shf_result = shf_operand >> shf_amount;
      end else begin
         shf_result = shf_operand << shf_amount;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic rq_t rq(input logic [W-1:0] op, input int amt, input logic r, input logic a);
      rq_t x;
      x.op    = op;
      x.amt   = amt[E:0];
      x.right = r;
      x.arith = a;
      return x;
   endfunction

   function automatic vec_t mk(input logic [1:0] v, input rq_t r0, input rq_t r1, input logic rr,
                               input logic [1:0] er, input logic erv, input logic [W-1:0] eres,
                               input logic eid);
      vec_t x;
      x.valid = v; x.r0 = r0; x.r1 = r1; x.rr = rr;
      x.exp_ready = er; x.exp_rv = erv; x.exp_res = eres; x.exp_id = eid;
      return x;
   endfunction

   task automatic drive(input logic [1:0] v, input rq_t r0, input rq_t r1, input logic rr);
      req_valid   = v;
      req_operand = {r1.op, r0.op};
      req_amount  = {r1.amt, r0.amt};
      req_right   = {r1.right, r0.right};
      req_arith   = {r1.arith, r0.arith};
      resp_ready  = rr;
   endtask

   initial begin
      rq_t idle, l0, l1, l3;
      vec_t v;
      idle = rq('0, 0, 1'b0, 1'b0);
      l0   = rq(30'h1, 1, 1'b0, 1'b0);
      l1   = rq(30'h1, 2, 1'b0, 1'b0);
      l3   = rq(30'h3, 0, 1'b0, 1'b0);

      // single shifts of each flavour
      vecs.push_back(mk(2'b01, rq(30'h00000F00, 4, 0, 0), idle, 1, 2'b01, 1, 30'h0000F000, 0));
      vecs.push_back(mk(2'b00, idle, idle, 1, 2'b00, 0, '0, 0));
      vecs.push_back(mk(2'b10, idle, rq(30'h20000000, 4, 1, 1), 1, 2'b10, 1, 30'h3E000000, 1));
      vecs.push_back(mk(2'b01, rq(30'h20000000, 4, 1, 0), idle, 1, 2'b01, 1, 30'h02000000, 0));
      vecs.push_back(mk(2'b10, idle, rq(30'h20000000, 40, 1, 1), 1, 2'b10, 1, 30'h3FFFFFFF, 1));
      vecs.push_back(mk(2'b01, rq(30'h00012345, 40, 0, 0), idle, 1, 2'b01, 1, 30'h00000000, 0));
      vecs.push_back(mk(2'b01, rq(30'h00000F00, 4, 0, 1), idle, 1, 2'b01, 1, 30'h0000F000, 0));
      vecs.push_back(mk(2'b10, idle, l3, 1, 2'b10, 1, 30'h3, 1));
      vecs.push_back(mk(2'b00, idle, idle, 1, 2'b00, 0, '0, 0));
      // round-robin fairness, one result per cycle
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(2'b11, l0, l1, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 1,
                           (i % 2 == 0) ? 30'h2 : 30'h4, (i % 2 == 0) ? 1'b0 : 1'b1));
      end
      // backpressure holds the last result, then drain + grant on one edge
      for (int i = 0; i < 3; i++) begin
         vecs.push_back(mk(2'b11, l0, l1, 0, 2'b00, 1, 30'h4, 1));
      end
      vecs.push_back(mk(2'b11, l0, l1, 1, 2'b01, 1, 30'h2, 0));
      // withdrawn request while stalled leaves ptr pointing at requester 1
      vecs.push_back(mk(2'b10, idle, l1, 0, 2'b00, 1, 30'h2, 0));
      vecs.push_back(mk(2'b00, idle, idle, 1, 2'b00, 0, '0, 0));
      vecs.push_back(mk(2'b11, l0, l1, 1, 2'b10, 1, 30'h4, 1));
      vecs.push_back(mk(2'b00, idle, idle, 1, 2'b00, 0, '0, 0));

      // reset and idle
      rst = 1'b1;
      drive(2'b11, l0, l1, 1'b1);
      @(negedge clk);
      #1 chk("ready_in_reset", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("reset_rv", 32'(resp_valid), 32'h0);
      chk("reset_id", 32'(resp_id), 32'h0);
      chk("reset_res", 32'(resp_result), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, idle, idle, 1'b1);
      #1 chk("idle_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);

      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v.valid, v.r0, v.r1, v.rr);
         #1 chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(v.exp_ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rv", i), 32'(resp_valid), 32'(v.exp_rv));
         if (v.exp_rv) begin
            chk($sformatf("v%0d_res", i), 32'(resp_result), 32'(v.exp_res));
            chk($sformatf("v%0d_id", i), 32'(resp_id), 32'(v.exp_id));
         end
         @(negedge clk);
      end

      // reset while FULL and stalled discards the result and rewinds ptr
      drive(2'b01, l0, idle, 1'b0);
      #1 chk("pre_rst_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1 chk("pre_rst_rv", 32'(resp_valid), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("post_rst_rv", 32'(resp_valid), 32'h0);
      chk("post_rst_res", 32'(resp_result), 32'h0);
      chk("post_rst_id", 32'(resp_id), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b11, l0, l1, 1'b1);
      #1 chk("post_rst_ptr_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("post_rst_first_res", 32'(resp_result), 32'h2);
      chk("post_rst_first_id", 32'(resp_id), 32'h0);
      @(negedge clk);
      drive(2'b00, idle, idle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin controller that shares one mantissa shifter instance between `N_REQ` requesters, such as exponent alignment, normalization and rounding. Each requester uses a valid/ready handshake. The block drives the shifter's operand and control inputs from the granted request and captures the shifter result in a one-entry output register. Results are returned on a single valid/ready response port, tagged with the requester index.

## Interface
Parameters:
- `M`, 23, mantissa width.
- `E`, 8, exponent width; shift amount is E+1 bits.
- `extra_bits_mantissa`, 7, extra mantissa bits; W = M+extra_bits_mantissa (30 by default).
- `N_REQ`, 2, number of requesters, 2..8. IW = max(1, clog2(N_REQ)).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_operand`  in  N_REQ*W  operands; slice i = bits [i*W +: W].
- `req_amount`  in  N_REQ*(E+1)  unsigned shift amounts, sliced like `req_operand`.
- `req_right`  in  N_REQ  1 = right shift, 0 = left shift.
- `req_arith`  in  N_REQ  1 = arithmetic; applies to right shifts only.
- `shf_operand`  out  W  to shifter `number_input`.
- `shf_amount`  out  E+1  to shifter `shift_amount`.
- `shf_right`  out  1  to shifter `right_shift`.
- `shf_arith`  out  1  to shifter `arithmetic_shift`.
- `shf_result`  in  W  from shifter `number_output`; combinational return path.
- `resp_valid`  out  1  response register holds a result.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_result`  out  W  registered shift result.
- `resp_id`  out  IW  index of the requester that produced `resp_result`.

## Operation
- Output state machine, two states:
  - EMPTY: `resp_valid` = 0.
  - FULL: `resp_valid` = 1.
- `can_accept` = EMPTY, or (FULL and `resp_ready`).
- Arbitration:
  - Round-robin pointer `ptr` (IW bits).
  - Grant goes to the first i with `req_valid[i]` = 1, searching ptr, ptr+1, …, wrapping modulo N_REQ.
  - `req_ready[i]` = `can_accept` and grant == i. Purely combinational from `req_valid`, `ptr`, state and `resp_ready`.
- On a grant to i:
  - Shifter inputs take slice i.
  - On the edge, `resp_result` <= `shf_result`, `resp_id` <= i, state <= FULL, `ptr` <= (i+1) mod N_REQ.
- With no grant:
  - Shifter inputs are driven from slice `ptr`; the values are don't-care.
  - `ptr` is held.
  - FULL and `resp_ready` -> EMPTY.
  - FULL and not `resp_ready` -> FULL.
- Simultaneous drain and grant in FULL: the new result replaces the old in the same edge, the state stays FULL, and no bubble is inserted.
- The arbiter does not check or modify the amount; amounts >= W pass through unchanged.
- Expected shifter results:
  - Amount >= W with logical or left shift gives 0.
  - Amount >= W with arithmetic right shift gives all bits equal to operand bit W-1.
  - `req_arith` with `req_right` = 0 behaves as a left shift.
- Requester obligation: operand and control stay stable while valid and not ready. Requesters may deassert valid before ready; the block tolerates this.
- Fairness: a continuously valid requester is granted within N_REQ accepted transactions.
- Reset (synchronous, any state, including mid-hold):
  - state = EMPTY, `resp_valid` = 0, `resp_result` = 0, `resp_id` = 0, `ptr` = 0.
  - `req_ready` = 0 during the reset cycle.
  - Any in-flight result is discarded.

## Timing
- Latency: request accepted on edge n; result visible on `resp_*` after edge n, in cycle n+1.
- Throughput: 1 request/cycle while `resp_ready` stays high.
- Shifter path is combinational from `req_*` to `resp_result` register input, within one cycle.
- `resp_valid`, `resp_result` and `resp_id` are held stable while `resp_valid` = 1 and `resp_ready` = 0.
- No combinational path from `req_*` to `resp_*`.
- Combinational path `resp_ready` -> `req_ready` exists.

## Test plan
- Reset then idle: after `rst` pulse, `resp_valid` = 0, `resp_id` = 0, `req_ready` = 0b00. Assert `rst` while FULL and `resp_ready` = 0: the next cycle shows `resp_valid` = 0.
- Single left shift: req0 operand 0x00000F00, amount 4, right = 0, one cycle -> next cycle `resp_valid` = 1, `resp_result` = 0x0000F000, `resp_id` = 0.
- Right shift types: operand 0x20000000, amount 4, right = 1.
  - arith = 1 -> `resp_result` 0x3E000000.
  - arith = 0 -> `resp_result` 0x02000000.
  - amount 40 with arith = 1 -> 0x3FFFFFFF.
- Round-robin fairness: both requesters hold valid for 6 cycles with `resp_ready` = 1 -> `resp_id` sequence 0,1,0,1,0,1 and one result per cycle.
- Backpressure: `resp_ready` = 0 for 3 cycles with both requesters valid.
  - One result is held unchanged and `req_ready` = 0b00.
  - Raise `resp_ready`: drain and next grant happen on the same edge with no bubble.
- Withdrawn request: req1 valid for 1 cycle while FULL and stalled, then dropped -> no response with `resp_id` = 1 and `ptr` unchanged.
